// File: rtl/rv_run_control_pkg.sv
// Shared definitions for the debug run-control sequencer.
//   XLEN          default datapath / PC width
//   RESET_VECTOR  default DPC loaded when halting straight out of reset
//   run_state_e   sequencer state encoding
//   CAUSE_*       dcsr.cause codes reported on the cause output
package rv_run_control_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam int          CAUSE_W      = 3;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_HALTED = 3'd3,
        ST_RESUME = 3'd4
    } run_state_e;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE         = 3'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_EBREAK       = 3'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_HALTREQ      = 3'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_STEP         = 3'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_RESETHALTREQ = 3'd5;

endpackage

// File: rtl/rv_run_control_halt_cause_prio.sv
// Halt-source priority encoder.
//   ebreak_hit  in   ebreak pending or executing with ebreakm set
//   haltreq     in   debugger halt request (level)
//   step_hit    in   single step completed one instruction
//   take        out  some halt source is active
//   cause       out  dcsr.cause of the winning source: ebreak > haltreq > step
module rv_run_control_halt_cause_prio
    import rv_run_control_pkg::*;
(
    input  logic               ebreak_hit,
    input  logic               haltreq,
    input  logic               step_hit,
    output logic               take,
    output logic [CAUSE_W-1:0] cause
);

    always_comb begin
        take  = ebreak_hit | haltreq | step_hit;
        cause = CAUSE_NONE;
        if (ebreak_hit) begin
            cause = CAUSE_EBREAK;
        end else if (haltreq) begin
            cause = CAUSE_HALTREQ;
        end else if (step_hit) begin
            cause = CAUSE_STEP;
        end
    end

endmodule

// File: rtl/rv_run_control.sv
// Debug run-control sequencer for rv_core: decides when the core runs, halts or
// single-steps, stalls control at instruction boundaries, records DPC / cause and
// requests a PC reload on resume.
//   clk, rst                 clock, synchronous active-high reset
//   haltreq, resumereq       debugger halt (level) / resume (pulse) requests
//   resethaltreq             halt before the first fetch after reset
//   step, ebreakm            dcsr.step / dcsr.ebreakm
//   ebreak, inst_retire      pulses from core control
//   boundary                 control sits in fetch with no bus transaction open
//   pc                       next instruction address
//   dpc_wr, dpc_wdata        debugger write port for DPC (honoured when halted)
//   halt_core, halted        stall request to control / debug-mode indicator
//   resume_ack, pc_load      one-cycle pulses when a resume is accepted
//   dpc, cause               debug PC and dcsr.cause
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_BOOT   | first cycle after reset; core held, decides on resethaltreq
// ST_RUN    | free running; halts at a boundary on ebreak / haltreq
// ST_STEP   | single step; additionally halts once an instruction retired
// ST_HALTED | debug mode; core held, DPC writable
// ST_RESUME | one cycle reloading pc from dpc before RUN or STEP
module rv_run_control
    import rv_run_control_pkg::*;
#(
    parameter int               Width       = XLEN,
    parameter logic [Width-1:0] ResetVector = Width'(RESET_VECTOR)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               haltreq,
    input  logic               resumereq,
    input  logic               resethaltreq,
    input  logic               step,
    input  logic               ebreakm,
    input  logic               ebreak,
    input  logic               inst_retire,
    input  logic               boundary,
    input  logic [Width-1:0]   pc,
    input  logic               dpc_wr,
    input  logic [Width-1:0]   dpc_wdata,
    output logic               halt_core,
    output logic               halted,
    output logic               resume_ack,
    output logic               pc_load,
    output logic [Width-1:0]   dpc,
    output logic [CAUSE_W-1:0] cause
);

    run_state_e         state_q;
    run_state_e         state_d;
    logic [Width-1:0]   dpc_q;
    logic [CAUSE_W-1:0] cause_q;
    logic               ebreak_pend_q;
    logic               retired_q;

    logic               ebreak_hit;
    logic               step_hit;
    logic               prio_take;
    logic [CAUSE_W-1:0] prio_cause;
    logic               take_halt;
    logic               active;

    assign active     = (state_q == ST_RUN) || (state_q == ST_STEP);
    // An ebreak in the current cycle counts just like one already pending.
    assign ebreak_hit = ebreak_pend_q | (ebreak & ebreakm);
    assign step_hit   = (state_q == ST_STEP) & retired_q;

    rv_run_control_halt_cause_prio u_prio (
        .ebreak_hit (ebreak_hit),
        .haltreq    (haltreq),
        .step_hit   (step_hit),
        .take       (prio_take),
        .cause      (prio_cause)
    );

    always_comb begin
        state_d    = state_q;
        halt_core  = 1'b0;
        halted     = 1'b0;
        resume_ack = 1'b0;
        pc_load    = 1'b0;
        take_halt  = 1'b0;
        case (state_q)
            ST_BOOT: begin
                halt_core = 1'b1;
                state_d   = resethaltreq ? ST_HALTED : ST_RUN;
            end
            ST_RUN, ST_STEP: begin
                if (boundary && prio_take) begin
                    halt_core = 1'b1;
                    take_halt = 1'b1;
                    state_d   = ST_HALTED;
                end
            end
            ST_HALTED: begin
                halt_core = 1'b1;
                halted    = 1'b1;
                // A fresh haltreq wins over a simultaneous resume.
                if (resumereq && !haltreq) begin
                    state_d = ST_RESUME;
                end
            end
            ST_RESUME: begin
                halt_core  = 1'b1;
                pc_load    = 1'b1;
                resume_ack = 1'b1;
                state_d    = step ? ST_STEP : ST_RUN;
            end
            default: begin
                halt_core = 1'b1;
                state_d   = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            dpc_q         <= ResetVector;
            cause_q       <= CAUSE_NONE;
            ebreak_pend_q <= 1'b0;
            retired_q     <= 1'b0;
        end else begin
            state_q <= state_d;

            if (take_halt) begin
                dpc_q   <= pc;
                cause_q <= prio_cause;
            end else if ((state_q == ST_BOOT) && resethaltreq) begin
                dpc_q   <= ResetVector;
                cause_q <= CAUSE_RESETHALTREQ;
            end else if ((state_q == ST_HALTED) && dpc_wr) begin
                dpc_q <= dpc_wdata;
            end

            if (take_halt) begin
                ebreak_pend_q <= 1'b0;
            end else if (active && ebreak && ebreakm) begin
                ebreak_pend_q <= 1'b1;
            end

            // Each step starts counting retirements afresh.
            if ((state_q == ST_RESUME) && (state_d == ST_STEP)) begin
                retired_q <= 1'b0;
            end else if (inst_retire) begin
                retired_q <= 1'b1;
            end
        end
    end

    assign dpc   = dpc_q;
    assign cause = cause_q;

endmodule
